// File: rtl/exc_commit_ctrl_pkg.sv
// Shared definitions for the exception commit controller: exception vector bit
// positions, redirect FSM state encoding and the default handler entry address.
package exc_commit_ctrl_pkg;

  localparam logic [31:0] EXC_ENTRY_DEFAULT = 32'hBFC00380;

  localparam int EXC_VEC_W  = 7;
  localparam int EV_PC_ADEL = 6;
  localparam int EV_RI      = 5;
  localparam int EV_OV      = 4;
  localparam int EV_SYSCALL = 3;
  localparam int EV_BREAK   = 2;
  localparam int EV_ADEL    = 1;
  localparam int EV_ADES    = 0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } redir_state_e;

endpackage

// File: rtl/exc_redirect_fsm.sv
// Redirect sequencer: on a committed exception or ERET it latches the target,
// pulses flush for one cycle, then holds the redirect request until accepted.
//
// state    | meaning
// RUN      | normal execution, watching for a commit that redirects
// FLUSH    | one-cycle pipeline invalidate
// REDIRECT | redirect_valid held with a stable target until redirect_ready
module exc_redirect_fsm
  import exc_commit_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         commit_i,
  input  logic         int_handle_i,
  input  logic         eret_i,
  input  logic [31:0]  epc_value_i,
  input  logic         redirect_ready_i,
  output redir_state_e state_o,
  output logic         flush_o,
  output logic         redirect_valid_o,
  output logic [31:0]  redirect_pc_o
);

  redir_state_e state_q;
  logic         flush_q;
  logic         redirect_valid_q;
  logic [31:0]  target_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= RUN;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      target_q         <= '0;
    end else begin
      case (state_q)
        RUN: begin
          // exception wins over a coincident ERET
          if (commit_i && int_handle_i) begin
            target_q <= EXC_ENTRY;
            flush_q  <= 1'b1;
            state_q  <= FLUSH;
          end else if (commit_i && eret_i) begin
            target_q <= epc_value_i;
            flush_q  <= 1'b1;
            state_q  <= FLUSH;
          end
        end
        FLUSH: begin
          flush_q          <= 1'b0;
          redirect_valid_q <= 1'b1;
          state_q          <= REDIRECT;
        end
        REDIRECT: begin
          if (redirect_ready_i) begin
            redirect_valid_q <= 1'b0;
            state_q          <= RUN;
          end
        end
        default: begin
          flush_q          <= 1'b0;
          redirect_valid_q <= 1'b0;
          state_q          <= RUN;
        end
      endcase
    end
  end

  assign state_o          = state_q;
  assign flush_o          = flush_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = target_q;

endmodule

// File: rtl/exc_commit_ctrl.sv
// Exception commit controller: tracks ID/EX instruction attributes, presents
// the exception vector to CP0 and sequences the flush/redirect.
// Delay-slot tracking is enabled by defining EXC_DELAY_SLOT_EN.
module exc_commit_ctrl
  import exc_commit_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          if_pc,
  input  logic                 if_to_id_go,
  input  logic                 id_ri,
  input  logic                 id_is_branch,
  input  logic                 id_to_ex_go,
  input  logic                 ex_ov,
  input  logic                 ex_syscall,
  input  logic                 ex_break,
  input  logic                 ex_adel,
  input  logic                 ex_ades,
  input  logic                 ex_eret,
  input  logic [31:0]          ex_badvaddr,
  input  logic                 ex_ready_in,
  input  logic                 ex_int_handle,
  input  logic [31:0]          epc_value,
  output logic [EXC_VEC_W-1:0] exc_vec,
  output logic                 exc_bd,
  output logic [31:0]          epc_out,
  output logic [31:0]          badvaddr_out,
  output logic                 eret_out,
  output logic                 exe_ready_go,
  output logic                 exe_refresh,
  output logic                 flush,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  input  logic                 redirect_ready
);

  redir_state_e        state;
  logic                flush_q;
  logic                redirect_valid_q;
  logic [31:0]         redirect_pc_q;
  logic                run;
  logic                go_d;
  logic                eret_d;
  logic [EXC_VEC_W-1:0] exc_vec_d;
  logic                bd;
  logic [31:0]         epc_d;

  logic        id_valid_q, id_pcadel_q;
  logic [31:0] id_pc_q;
  logic        ex_valid_q, ex_pcadel_q, ex_ri_q;
  logic [31:0] ex_pc_q;

  assign run    = (state == RUN);
  assign go_d   = ex_valid_q & ex_ready_in & run;
  assign eret_d = ex_valid_q & ex_eret & run;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_q  <= 1'b0;
      id_pcadel_q <= 1'b0;
      id_pc_q     <= '0;
      ex_valid_q  <= 1'b0;
      ex_pcadel_q <= 1'b0;
      ex_ri_q     <= 1'b0;
      ex_pc_q     <= '0;
    end else if (flush_q) begin
      id_valid_q  <= 1'b0;
      id_pcadel_q <= 1'b0;
      ex_valid_q  <= 1'b0;
      ex_pcadel_q <= 1'b0;
      ex_ri_q     <= 1'b0;
    end else if (run) begin
      if (if_to_id_go) begin
        id_valid_q  <= 1'b1;
        id_pc_q     <= if_pc;
        id_pcadel_q <= |if_pc[1:0];
      end
      if (id_to_ex_go) begin
        ex_valid_q  <= id_valid_q;
        ex_pc_q     <= id_pc_q;
        ex_pcadel_q <= id_pcadel_q;
        ex_ri_q     <= id_ri;
      end else if (go_d) begin
        ex_valid_q  <= 1'b0;
      end
    end
  end

`ifdef EXC_DELAY_SLOT_EN
  logic id_bd_q, ex_bd_q;

  // the incoming instruction is a delay slot if the one it follows in ID branches
  always_ff @(posedge clk) begin
    if (rst || flush_q) begin
      id_bd_q <= 1'b0;
      ex_bd_q <= 1'b0;
    end else if (run) begin
      if (if_to_id_go) id_bd_q <= id_valid_q & id_is_branch;
      if (id_to_ex_go) ex_bd_q <= id_bd_q;
    end
  end

  assign bd    = ex_bd_q;
  assign epc_d = ex_bd_q ? (ex_pc_q - 32'd4) : ex_pc_q;
`else
  logic unused_is_branch;
  assign unused_is_branch = id_is_branch;
  assign bd    = 1'b0;
  assign epc_d = ex_pc_q;
`endif

  always_comb begin
    exc_vec_d = '0;
    if (ex_valid_q && run) begin
      exc_vec_d[EV_PC_ADEL] = ex_pcadel_q;
      exc_vec_d[EV_RI]      = ex_ri_q;
      exc_vec_d[EV_OV]      = ex_ov;
      exc_vec_d[EV_SYSCALL] = ex_syscall;
      exc_vec_d[EV_BREAK]   = ex_break;
      exc_vec_d[EV_ADEL]    = ex_adel;
      exc_vec_d[EV_ADES]    = ex_ades;
    end
  end

  exc_redirect_fsm #(.EXC_ENTRY(EXC_ENTRY)) u_fsm (
    .clk              (clk),
    .rst              (rst),
    .commit_i         (go_d),
    .int_handle_i     (ex_int_handle),
    .eret_i           (eret_d),
    .epc_value_i      (epc_value),
    .redirect_ready_i (redirect_ready),
    .state_o          (state),
    .flush_o          (flush_q),
    .redirect_valid_o (redirect_valid_q),
    .redirect_pc_o    (redirect_pc_q)
  );

  // everything reads zero while reset is held, even before the first edge
  assign exc_vec        = rst ? '0 : exc_vec_d;
  assign exc_bd         = ~rst & bd;
  assign epc_out        = rst ? '0 : epc_d;
  assign badvaddr_out   = rst ? '0 : (ex_pcadel_q ? ex_pc_q : ex_badvaddr);
  assign eret_out       = ~rst & eret_d;
  assign exe_ready_go   = ~rst & go_d;
  assign flush          = ~rst & flush_q;
  assign exe_refresh    = ~rst & flush_q;
  assign redirect_valid = ~rst & redirect_valid_q;
  assign redirect_pc    = rst ? '0 : redirect_pc_q;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl: table of single-instruction EX
// vectors plus hand sequences for redirect, delay slot, ERET and reset abort.
module tb_exc_commit_ctrl;

  localparam logic [31:0] ENTRY = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_to_id_go, id_ri, id_is_branch, id_to_ex_go;
  logic        ex_ov, ex_syscall, ex_break, ex_adel, ex_ades, ex_eret;
  logic [31:0] ex_badvaddr;
  logic        ex_ready_in, ex_int_handle;
  logic [31:0] epc_value;
  logic [6:0]  exc_vec;
  logic        exc_bd;
  logic [31:0] epc_out, badvaddr_out;
  logic        eret_out, exe_ready_go, exe_refresh, flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  int checks = 0;
  int errors = 0;

  exc_commit_ctrl dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_to_id_go(if_to_id_go),
    .id_ri(id_ri), .id_is_branch(id_is_branch), .id_to_ex_go(id_to_ex_go),
    .ex_ov(ex_ov), .ex_syscall(ex_syscall), .ex_break(ex_break),
    .ex_adel(ex_adel), .ex_ades(ex_ades), .ex_eret(ex_eret),
    .ex_badvaddr(ex_badvaddr), .ex_ready_in(ex_ready_in),
    .ex_int_handle(ex_int_handle), .epc_value(epc_value),
    .exc_vec(exc_vec), .exc_bd(exc_bd), .epc_out(epc_out),
    .badvaddr_out(badvaddr_out), .eret_out(eret_out),
    .exe_ready_go(exe_ready_go), .exe_refresh(exe_refresh), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        ri;
    logic [4:0]  flags;   // {ov, syscall, break, adel, ades}
    logic        eret;
    logic [31:0] bva;
    logic        rdy;
    logic [6:0]  exp_vec;
    logic [31:0] exp_bva;
    logic        exp_go;
    logic        exp_eret;
  } vec_t;

  vec_t tv[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    if_to_id_go = 0; id_ri = 0; id_is_branch = 0; id_to_ex_go = 0;
    ex_ov = 0; ex_syscall = 0; ex_break = 0; ex_adel = 0; ex_ades = 0;
    ex_eret = 0; ex_badvaddr = 0; ex_ready_in = 0; ex_int_handle = 0;
    redirect_ready = 0;
  endtask

  // fetch pc into ID, move it to EX; returns at start of the EX cycle
  task automatic load(input logic [31:0] pc, input logic ri);
    tick(); clr_in();
    if_to_id_go = 1; if_pc = pc;
    tick();
    if_to_id_go = 0; id_to_ex_go = 1; id_ri = ri;
    tick();
    id_to_ex_go = 0; id_ri = 0;
  endtask

  // called at the negedge of the committing cycle
  task automatic redirect_seq(input logic [31:0] exp_pc, input string nm);
    int flushes = 0;
    tick();
    ex_ov = 0; ex_syscall = 0; ex_break = 0; ex_adel = 0; ex_ades = 0;
    ex_eret = 0; ex_int_handle = 0; epc_value = 32'h0;
    ex_ready_in = 1;
    if_to_id_go = 1; if_pc = 32'h3002; id_to_ex_go = 1;
    @(negedge clk);
    if (flush) flushes++;
    chk({nm, "_flush"}, flush, 1);
    chk({nm, "_refresh"}, exe_refresh, 1);
    chk({nm, "_vec_supp"}, exc_vec, 0);
    chk({nm, "_go_supp"}, exe_ready_go, 0);
    chk({nm, "_rv_in_flush"}, redirect_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      if (flush) flushes++;
      chk({nm, "_rv_hold"}, redirect_valid, 1);
      chk({nm, "_rpc"}, redirect_pc, exp_pc);
    end
    tick(); redirect_ready = 1;
    @(negedge clk);
    if (flush) flushes++;
    chk({nm, "_rv_accept"}, redirect_valid, 1);
    tick(); redirect_ready = 0; if_to_id_go = 0; id_to_ex_go = 0;
    @(negedge clk);
    if (flush) flushes++;
    chk({nm, "_flush_count"}, flushes, 1);
    chk({nm, "_rv_done"}, redirect_valid, 0);
    chk({nm, "_no_stale_ex"}, exe_ready_go, 0);
    ex_ready_in = 0;
  endtask

  initial begin
    logic        exp_bd;
    logic [31:0] exp_epc;

    tv[0]  = '{32'h1000, 0, 5'b10000, 0, 32'h0,        0, 7'b0010000, 32'h0,        0, 0};
    tv[1]  = '{32'h3002, 0, 5'b00000, 0, 32'h5555,     0, 7'b1000000, 32'h3002,     0, 0};
    tv[2]  = '{32'h3001, 0, 5'b00000, 0, 32'h0,        0, 7'b1000000, 32'h3001,     0, 0};
    tv[3]  = '{32'h5000, 1, 5'b00000, 0, 32'h0,        0, 7'b0100000, 32'h0,        0, 0};
    tv[4]  = '{32'h5004, 0, 5'b01000, 0, 32'h0,        0, 7'b0001000, 32'h0,        0, 0};
    tv[5]  = '{32'h5008, 0, 5'b00100, 0, 32'h0,        0, 7'b0000100, 32'h0,        0, 0};
    tv[6]  = '{32'h500c, 0, 5'b00010, 0, 32'h80000001, 0, 7'b0000010, 32'h80000001, 0, 0};
    tv[7]  = '{32'h5010, 0, 5'b00001, 0, 32'h1234,     0, 7'b0000001, 32'h1234,     0, 0};
    tv[8]  = '{32'h6000, 0, 5'b00000, 1, 32'h0,        0, 7'b0000000, 32'h0,        0, 1};
    tv[9]  = '{32'h7000, 0, 5'b00000, 0, 32'h0,        1, 7'b0000000, 32'h0,        1, 0};
    tv[10] = '{32'h3003, 1, 5'b10001, 0, 32'h9,        0, 7'b1110001, 32'h3003,     0, 0};

    // reset with busy-looking inputs: all outputs must read zero
    rst = 1; clr_in(); if_pc = 32'h0;
    ex_badvaddr = 32'hFFFFFFFF; ex_ready_in = 1; ex_ov = 1; ex_eret = 1;
    epc_value = 32'h1234; if_to_id_go = 1; id_to_ex_go = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vec", exc_vec, 0);
    chk("rst_epc", epc_out, 0);
    chk("rst_bva", badvaddr_out, 0);
    chk("rst_bd", exc_bd, 0);
    chk("rst_eret", eret_out, 0);
    chk("rst_go", exe_ready_go, 0);
    chk("rst_flush", flush, 0);
    chk("rst_rv", redirect_valid, 0);
    chk("rst_rpc", redirect_pc, 0);
    tick(); rst = 0; clr_in();
    @(negedge clk);
    chk("post_rst_vec", exc_vec, 0);
    chk("post_rst_rv", redirect_valid, 0);

    foreach (tv[i]) begin
      load(tv[i].pc, tv[i].ri);
      {ex_ov, ex_syscall, ex_break, ex_adel, ex_ades} = tv[i].flags;
      ex_eret = tv[i].eret; ex_badvaddr = tv[i].bva; ex_ready_in = tv[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_vec", i), exc_vec, tv[i].exp_vec);
      chk($sformatf("v%0d_bva", i), badvaddr_out, tv[i].exp_bva);
      chk($sformatf("v%0d_epc", i), epc_out, tv[i].pc);
      chk($sformatf("v%0d_go", i), exe_ready_go, tv[i].exp_go);
      chk($sformatf("v%0d_eret", i), eret_out, tv[i].exp_eret);
      chk($sformatf("v%0d_rv", i), redirect_valid, 0);
    end

    // overflow with interrupt request -> flush and redirect to handler entry
    load(32'h1000, 0);
    ex_ov = 1; ex_ready_in = 1; ex_int_handle = 1;
    @(negedge clk);
    chk("ov_vec", exc_vec, 7'b0010000);
    chk("ov_epc", epc_out, 32'h1000);
    chk("ov_go", exe_ready_go, 1);
    redirect_seq(ENTRY, "ov");

    // branch at 0x2000, syscall in its delay slot at 0x2004
`ifdef EXC_DELAY_SLOT_EN
    exp_bd = 1; exp_epc = 32'h2000;
`else
    exp_bd = 0; exp_epc = 32'h2004;
`endif
    tick(); clr_in();
    if_to_id_go = 1; if_pc = 32'h2000;
    tick();
    if_to_id_go = 1; if_pc = 32'h2004; id_is_branch = 1; id_to_ex_go = 1;
    tick();
    if_to_id_go = 0; id_is_branch = 0; id_to_ex_go = 1;
    tick();
    id_to_ex_go = 0; ex_syscall = 1; ex_ready_in = 1; ex_int_handle = 1;
    @(negedge clk);
    chk("ds_vec", exc_vec, 7'b0001000);
    chk("ds_bd", exc_bd, exp_bd);
    chk("ds_epc", epc_out, exp_epc);
    redirect_seq(ENTRY, "ds");

    // ERET alone returns to the sampled EPC
    load(32'h4000, 0);
    ex_eret = 1; ex_ready_in = 1; epc_value = 32'h4abc;
    @(negedge clk);
    chk("eret_out", eret_out, 1);
    chk("eret_vec", exc_vec, 0);
    redirect_seq(32'h4abc, "eret");

    // ERET with simultaneous exception request -> handler entry
    load(32'h4100, 0);
    ex_eret = 1; ex_ready_in = 1; ex_int_handle = 1; epc_value = 32'h4abc;
    @(negedge clk);
    chk("eretx_go", exe_ready_go, 1);
    redirect_seq(ENTRY, "eretx");

    // redirect stalled for 5 cycles then reset aborts it
    load(32'h1000, 0);
    ex_ov = 1; ex_ready_in = 1; ex_int_handle = 1;
    @(negedge clk);
    chk("ab_go", exe_ready_go, 1);
    tick(); clr_in();
    @(negedge clk);
    chk("ab_flush", flush, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("ab_rv_stall%0d", i), redirect_valid, 1);
      tick();
    end
    rst = 1;
    @(negedge clk);
    chk("ab_rst_rv", redirect_valid, 0);
    chk("ab_rst_rpc", redirect_pc, 0);
    chk("ab_rst_flush", flush, 0);
    tick(); rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("ab_post_rv%0d", i), redirect_valid, 0);
      chk($sformatf("ab_post_flush%0d", i), flush, 0);
      tick();
    end
    load(32'h7000, 0);
    ex_ready_in = 1;
    @(negedge clk);
    chk("ab_run_go", exe_ready_go, 1);
    chk("ab_run_rpc", redirect_pc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/exc_commit_ctrl.md
EXC_COMMIT_CTRL -- requirements
Module: exc_commit_ctrl

Interface
REQ-001 SHALL have parameter EXC_ENTRY, default 32'hBFC00380, the exception handler redirect PC.
REQ-002 SHALL have port clk, input, 1, the system clock.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset; clock clk.
REQ-004 SHALL have port if_pc, input, 32, the PC of the fetched instruction.
REQ-005 SHALL have port if_to_id_go, input, 1, indicating the IF instruction enters ID this cycle.
REQ-006 SHALL have port id_ri, input, 1, indicating the ID instruction is a reserved instruction.
REQ-007 SHALL have port id_is_branch, input, 1, indicating the ID instruction is a branch or jump.
REQ-008 SHALL have port id_to_ex_go, input, 1, indicating the ID instruction enters EX this cycle.
REQ-009 SHALL have port ex_ov/ex_syscall/ex_break/ex_adel/ex_ades, input, 1 each, the EX exception flags.
REQ-010 SHALL have port ex_eret, input, 1, indicating the EX instruction is ERET.
REQ-011 SHALL have port ex_badvaddr, input, 32, the EX data address.
REQ-012 SHALL have port ex_ready_in, input, 1, indicating EX work is complete.
REQ-013 SHALL have port ex_int_handle, input, 1, the CP0 take-exception-or-interrupt request.
REQ-014 SHALL have port epc_value, input, 32, the current CP0 EPC.
REQ-015 SHALL have port exc_vec, output, 7, {pc_adel, ri, ov, syscall, break, adel, ades} to CP0.
REQ-016 SHALL have port exc_bd, output, 1, the branch-delay flag to CP0.
REQ-017 SHALL have port epc_out, output, 32, the EPC candidate to CP0.
REQ-018 SHALL have port badvaddr_out, output, 32, the BadVAddr candidate to CP0.
REQ-019 SHALL have port eret_out, output, 1, the ERET indication to CP0.
REQ-020 SHALL have ports exe_ready_go and exe_refresh, output, 1 each, the CP0 commit strobe and the flush strobe.
REQ-021 SHALL have port flush, output, 1, the pipeline-wide invalidate.
REQ-022 SHALL have ports redirect_valid (output, 1), redirect_pc (output, 32) and redirect_ready (input, 1), forming the PC redirect handshake.

Function
REQ-023 SHALL track id_valid, id_pc, id_pcadel (|if_pc[1:0]) and id_bd; these load on if_to_id_go and clear on flush.
REQ-024 SHALL track ex_valid, ex_pc, ex_pcadel, ex_ri and ex_bd; these load on id_to_ex_go and clear on flush or when an EX instruction leaves without id_to_ex_go.
REQ-025 SHALL set id_bd when the instruction preceding it in ID had id_is_branch=1.
REQ-026 SHALL drive exc_vec = ex_valid & state==RUN ? {ex_pcadel, ex_ri, ex_ov, ex_syscall, ex_break, ex_adel, ex_ades} : 0; the vector is combinational.
REQ-027 SHALL drive epc_out = ex_bd ? ex_pc-32'd4 : ex_pc, using mod-2^32 arithmetic.
REQ-028 SHALL drive badvaddr_out = ex_pcadel ? ex_pc : ex_badvaddr.
REQ-029 SHALL drive exe_ready_go = ex_valid & ex_ready_in & state==RUN.
REQ-030 SHALL drive eret_out = ex_valid & ex_eret & state==RUN.
REQ-031 SHALL implement an FSM with states RUN, FLUSH and REDIRECT.
REQ-032 SHALL, in RUN with exe_ready_go & ex_int_handle, latch target=EXC_ENTRY and go to FLUSH.
REQ-033 SHALL, in RUN with exe_ready_go & eret_out & ~ex_int_handle, latch target=epc_value (sampled that cycle) and go to FLUSH.
REQ-034 SHALL give exception priority over ERET when both occur in the same cycle.
REQ-035 SHALL, in FLUSH, assert flush=exe_refresh=1 for exactly one cycle, then go to REDIRECT.
REQ-036 SHALL, in REDIRECT, hold redirect_valid=1 and redirect_pc=target stable until redirect_ready, then return to RUN in the next cycle.
REQ-037 SHALL ignore if_to_id_go and id_to_ex_go in FLUSH and REDIRECT.
REQ-038 SHALL suppress exc_vec and exe_ready_go in FLUSH and REDIRECT, so CP0 cannot commit twice.

Reset
REQ-039 SHALL, on rst, return state to RUN and clear all valids, bd flags and target.
REQ-040 SHALL drive all outputs to 0 while rst is asserted.
REQ-041 SHALL let rst in FLUSH or REDIRECT abort the redirect with no further redirect_valid.

Configuration
REQ-042 SHALL, with EXC_DELAY_SLOT_EN defined, implement delay-slot tracking per REQ-025/027.
REQ-043 SHALL, without EXC_DELAY_SLOT_EN, tie exc_bd=0, set epc_out=ex_pc and leave id_is_branch unused.

Structure
REQ-044 SHALL place exc_vec bit indices, FSM state encodings and the default EXC_ENTRY in the shared package.
REQ-045 SHALL implement the FSM and target register as the single sub-module exc_redirect_fsm.

Verification
REQ-046 SHALL cover: EX ov=1, ex_pc=32'h1000, ex_int_handle=1 -> exc_vec=7'b0010000, epc_out=32'h1000, one flush pulse, redirect_pc=32'hBFC00380.
REQ-047 SHALL cover: branch at 32'h2000, delay slot at 32'h2004 with syscall -> exc_bd=1, epc_out=32'h2000.
REQ-048 SHALL cover: if_pc=32'h3002 reaching EX -> exc_vec[6]=1, badvaddr_out=32'h3002.
REQ-049 SHALL cover: ERET with epc_value=32'h4abc, no exception -> redirect_pc=32'h4abc.
REQ-050 SHALL cover: ERET with ex_int_handle=1 in the same cycle -> redirect_pc=EXC_ENTRY.
REQ-051 SHALL cover: redirect_ready held 0 for 5 cycles, then rst -> redirect_valid stays 0 after reset and state is RUN.
